spi_slave_wb_bridge: RTL and testbench
======================================

// Module: spi_slave_wb_bridge
// PURPOSE
// - SPI mode-0 slave (CPOL=0, CPHA=0, MSB first, cs active-low) that turns SPI frames into Wishbone master cycles.
// - Sits opposite the SPI master: an FPGA or second board exposes its 8-bit Wishbone register space over SPI.
// - Frame: byte0 = {rw, addr[6:0]} (rw=1 read); bytes 1..N = data; address auto-increments per data byte.
// PARAMETERS
// - SYNC_STAGES  2   flops on sck/cs/mosi before edge detection (>=2)
// - ADDR_WIDTH   7   Wishbone address width (command byte supplies 7 bits, upper bits 0)
// - WB_TIMEOUT   15  CLK_I cycles to wait for ACK_I before abandoning a cycle
// PORTS
// - CLK_I     in   1           system clock; sck is asynchronous to it
// - RST_I     in   1           synchronous, active-low reset
// - sck       in   1           SPI clock from master
// - cs        in   1           chip select, active-low
// - mosi      in   1           serial data from master
// - miso      out  1           serial data to master
// - miso_oe   out  1           1 while cs (synchronised) is low; pad tri-state enable
// - ADR_O     out  ADDR_WIDTH  Wishbone address
// - DAT_O     out  8           Wishbone write data
// - DAT_I     in   8           Wishbone read data
// - WE_O      out  1           1 = write cycle
// - CYC_O     out  1           cycle in progress
// - STB_O     out  1           strobe; equals CYC_O
// - ACK_I     in   1           slave acknowledge
// - busy      out  1           1 while frame active or Wishbone cycle outstanding
// BEHAVIOUR
// - Reset (RST_I=0 at a CLK_I edge): CYC_O=STB_O=WE_O=0, ADR_O=0, DAT_O=0, miso=0, miso_oe=0, busy=0, status=0.
// - Reset abandons any frame or Wishbone cycle at once; no completion is waited for.
// - Input path: sck/cs/mosi pass through SYNC_STAGES flops, then a 1-cycle edge detect.
//   - Latency from a pin edge to the internal edge pulse is SYNC_STAGES+1 CLK_I cycles.
// - SCK timing: half-period >= WB_TIMEOUT+SYNC_STAGES+4 CLK_I cycles, so the master's clkDiv setting must satisfy this bound.
// - Frame FSM states:
//   - IDLE -> CMD on cs fall.
//   - CMD -> DATA after the 8th sck rise.
//   - DATA stays in DATA across byte boundaries.
//   - Any state -> IDLE on cs rise.
// - Rx: mosi is sampled on each sck rise into rx_shift. A bit counter (3 bits) wraps 7->0 at every byte boundary.
// - CMD byte complete: latch rw and addr; ADR_O <= addr.
//   - If rw=1, launch a Wishbone read at addr on the same cycle.
// - Write data byte complete (rw=0): launch a Wishbone write with DAT_O=rx byte and ADR_O=addr, then addr <= addr+1.
//   - Address wraps 7'h7F -> 7'h00.
// - Read: each completed data byte launches a prefetch at addr+1 (addr increments first, with the same wrap).
// - Tx: miso = tx_shift[7]. tx_shift shifts left on each sck fall, except the fall that follows a byte's 8th rise.
//   - On that fall tx_shift loads the next byte.
// - Next-byte source:
//   - read data captured on ACK_I;
//   - 8'hFF if no read data is ready (sets status.overrun);
//   - 8'h00 in write frames.
// - On cs fall, tx_shift loads {overrun, timeout, 6'b0}. The master therefore clocks status out during the command byte.
//   - Both status bits clear after that load.
// - Wishbone FSM states:
//   - WB_IDLE -> WB_READ or WB_WRITE on launch: CYC_O=STB_O=1; WE_O=1 for writes.
//   - Cycle ends on the first CLK_I cycle with ACK_I=1: CYC_O=STB_O=WE_O=0 on the next edge, then WB_IDLE.
//   - ACK_I seen in WB_IDLE is ignored.
//   - Timeout: WB_TIMEOUT cycles without ACK_I -> drop CYC/STB and set status.timeout.
//     - A timed-out read supplies 8'hFF; a timed-out write is lost.
// - Launch while a cycle is still outstanding (protocol violation only): the new launch is dropped and status.overrun is set.
// - cs rise mid-byte: partial byte discarded, frame FSM -> IDLE.
//   - An in-flight Wishbone cycle still runs to ACK or timeout.
//   - A cs fall during that cycle starts a new CMD normally.
// - busy = (frame FSM != IDLE) | CYC_O.
// STRUCTURE
// - Package spi_wb_pkg: frame_state_t {IDLE, CMD, DATA}, wb_state_t {WB_IDLE, WB_READ, WB_WRITE},
//   CMD_RW_BIT=7, STATUS_OVERRUN_BIT=7, STATUS_TIMEOUT_BIT=6, TX_FILL_BYTE=8'hFF.
// - Sub-module spi_edge_sync (SYNC_STAGES param): synchroniser plus rise/fall pulses for one input.
//   - Instantiated for sck and cs; mosi uses only the synchroniser.
// - Top level holds frame FSM, rx/tx shifters, address counter, Wishbone FSM and timeout counter.
// TESTING
// - Write: cs low, send 8'h05, 8'hA5, cs high.
//   - Exactly one WB write: ADR_O=5, DAT_O=8'hA5, WE_O=1.
//   - CYC_O drops the cycle after ACK_I.
// - Burst read: memory model holds [0x10]=8'h11, [0x11]=8'h22; send 8'h90, 8'h00, 8'h00.
//   - miso returns 8'h00 (status), 8'h11, 8'h22.
//   - WB reads occur at 0x10, 0x11, 0x12 (prefetch).
// - Address wrap: write burst 8'h7F, 8'h01, 8'h02 -> WB writes at 0x7F then 0x00.
// - Timeout: slave never ACKs; read 8'h83, 8'h00.
//   - Data byte = 8'hFF; CYC_O drops after WB_TIMEOUT cycles.
//   - Next frame's status byte = 8'h40.
// - Abort: cs rises after 4 bits of the data byte in a write frame.
//   - No WB write is issued.
//   - A new frame writing 8'h01, 8'h3C then works.
// - Reset: RST_I low while CYC_O=1 -> next edge CYC_O=STB_O=0, busy=0, miso_oe=0; status reads 8'h00 afterwards.

Source files
------------

// File: rtl/spi_wb_pkg.sv
// Shared types and constants for the SPI-slave to Wishbone bridge.
package spi_wb_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA} frame_state_t;
  typedef enum logic [1:0] {WB_IDLE, WB_READ, WB_WRITE} wb_state_t;

  localparam int unsigned CMD_RW_BIT         = 7;
  localparam int unsigned STATUS_OVERRUN_BIT = 7;
  localparam int unsigned STATUS_TIMEOUT_BIT = 6;
  localparam logic [7:0]  TX_FILL_BYTE       = 8'hFF;

  // One Wishbone request as issued by the frame logic
  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [7:0] data;
  } wb_req_t;

  function automatic logic [7:0] status_byte(input logic overrun, input logic timeout);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_OVERRUN_BIT] = overrun;
    s[STATUS_TIMEOUT_BIT] = timeout;
    return s;
  endfunction

endpackage

// File: rtl/spi_slave_wb_bridge_if.sv
// SPI pins plus Wishbone master bus of the bridge; slave = bridge side.
interface spi_slave_wb_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 7
);
  logic                  sck;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [ADDR_WIDTH-1:0] ADR_O;
  logic [7:0]            DAT_O;
  logic [7:0]            DAT_I;
  logic                  WE_O;
  logic                  CYC_O;
  logic                  STB_O;
  logic                  ACK_I;
  logic                  busy;

  modport slave (
    input  sck, cs, mosi, DAT_I, ACK_I,
    output miso, miso_oe, ADR_O, DAT_O, WE_O, CYC_O, STB_O, busy
  );

  modport master (
    output sck, cs, mosi, DAT_I, ACK_I,
    input  miso, miso_oe, ADR_O, DAT_O, WE_O, CYC_O, STB_O, busy
  );
endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one asynchronous input with registered rise/fall pulses.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // Pulse appears SYNC_STAGES+1 cycles after the pin edge
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_wb_bridge.sv
// SPI mode-0 slave that turns {rw,addr} + data frames into Wishbone master cycles.
module spi_slave_wb_bridge
  import spi_wb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned WB_TIMEOUT  = 15
) (
  input logic                 CLK_I,
  input logic                 RST_I,
  spi_slave_wb_bridge_if.slave bus
);

  localparam int unsigned TMO_W = $clog2(WB_TIMEOUT + 1);

  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;

  logic [SYNC_STAGES-1:0] mosi_sync_q;

  frame_state_t          frame_q, frame_d;
  wb_state_t             wb_q, wb_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            rx_shift_q, rx_shift_d;
  logic [7:0]            tx_shift_q, tx_shift_d;
  logic                  byte_end_q, byte_end_d;
  logic                  rw_q, rw_d;
  logic [6:0]            addr_q, addr_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [7:0]            dat_q, dat_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  miso_oe_q, miso_oe_d;
  logic                  busy_q, busy_d;

  logic       launch;
  wb_req_t    req;
  logic [7:0] rx_byte;
  logic [6:0] next_addr;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk_i (CLK_I),
    .rst_ni(RST_I),
    .d_i   (bus.sck),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i (CLK_I),
    .rst_ni(RST_I),
    .d_i   (bus.cs),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      mosi_sync_q <= '0;
      frame_q     <= IDLE;
      wb_q        <= WB_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      tx_shift_q  <= 8'h00;
      byte_end_q  <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= 8'h00;
      tmo_q       <= '0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      frame_q     <= frame_d;
      wb_q        <= wb_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      byte_end_q  <= byte_end_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      tmo_q       <= tmo_d;
      miso_oe_q   <= miso_oe_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    frame_d    = frame_q;
    wb_d       = wb_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    byte_end_d = byte_end_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    tmo_d      = tmo_q;
    miso_oe_d  = miso_oe_q;
    launch     = 1'b0;
    req        = '0;
    rx_byte    = {rx_shift_q, mosi_s};
    next_addr  = addr_q + 7'd1;

    // Frame side: shifters, address counter and request generation
    if (cs_rise) begin
      frame_d    = IDLE;
      byte_end_d = 1'b0;
      miso_oe_d  = 1'b0;
    end else begin
      case (frame_q)
        IDLE: begin
          if (cs_fall) begin
            frame_d    = CMD;
            bit_cnt_d  = 3'd0;
            byte_end_d = 1'b0;
            tx_shift_d = status_byte(overrun_q, timeout_q);
            overrun_d  = 1'b0;
            timeout_d  = 1'b0;
            rd_valid_d = 1'b0;
            miso_oe_d  = 1'b1;
          end
        end
        CMD, DATA: begin
          if (sck_rise) begin
            rx_shift_d = rx_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_end_d = 1'b1;
              if (frame_q == CMD) begin
                frame_d = DATA;
                rw_d    = rx_byte[CMD_RW_BIT];
                addr_d  = rx_byte[6:0];
                if (wb_q == WB_IDLE) adr_d = ADDR_WIDTH'(rx_byte[6:0]);
                if (rx_byte[CMD_RW_BIT]) begin
                  launch   = 1'b1;
                  req.we   = 1'b0;
                  req.addr = rx_byte[6:0];
                end
              end else if (!rw_q) begin
                launch   = 1'b1;
                req.we   = 1'b1;
                req.addr = addr_q;
                req.data = rx_byte;
                addr_d   = next_addr;
              end else begin
                launch   = 1'b1;
                req.we   = 1'b0;
                req.addr = next_addr;
                addr_d   = next_addr;
              end
            end
          end
          // The fall after a byte's last rise presents the next byte instead of shifting
          if (sck_fall) begin
            if (byte_end_q) begin
              byte_end_d = 1'b0;
              if (!rw_q) begin
                tx_shift_d = 8'h00;
              end else if (rd_valid_q) begin
                tx_shift_d = rd_data_q;
                rd_valid_d = 1'b0;
              end else begin
                tx_shift_d = TX_FILL_BYTE;
                overrun_d  = 1'b1;
              end
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
          end
        end
        default: frame_d = IDLE;
      endcase
    end

    // Wishbone side: one outstanding cycle, ended by ACK_I or timeout
    case (wb_q)
      WB_IDLE: begin
        if (launch) begin
          wb_d  = req.we ? WB_WRITE : WB_READ;
          cyc_d = 1'b1;
          we_d  = req.we;
          adr_d = ADDR_WIDTH'(req.addr);
          tmo_d = '0;
          if (req.we) dat_d = req.data;
        end
      end
      WB_READ, WB_WRITE: begin
        if (launch) overrun_d = 1'b1;
        if (bus.ACK_I) begin
          wb_d  = WB_IDLE;
          cyc_d = 1'b0;
          we_d  = 1'b0;
          if (wb_q == WB_READ) begin
            rd_data_d  = bus.DAT_I;
            rd_valid_d = 1'b1;
          end
        end else if (tmo_q == TMO_W'(WB_TIMEOUT - 1)) begin
          wb_d      = WB_IDLE;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          timeout_d = 1'b1;
          if (wb_q == WB_READ) begin
            rd_data_d  = TX_FILL_BYTE;
            rd_valid_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: wb_d = WB_IDLE;
    endcase

    busy_d = (frame_d != IDLE) | cyc_d;
  end

  assign bus.miso    = tx_shift_q[7];
  assign bus.miso_oe = miso_oe_q;
  assign bus.ADR_O   = adr_q;
  assign bus.DAT_O   = dat_q;
  assign bus.WE_O    = we_q;
  assign bus.CYC_O   = cyc_q;
  assign bus.STB_O   = cyc_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_spi_slave_wb_bridge.sv
// Directed bench: SPI master driver, Wishbone memory responder, immediate-assertion checks.
module tb_spi_slave_wb_bridge;

  localparam int unsigned HALF = 30;

  logic clk;
  logic rst_n;

  spi_slave_wb_bridge_if #(.ADDR_WIDTH(7)) bus ();

  spi_slave_wb_bridge #(
    .SYNC_STAGES(2),
    .ADDR_WIDTH (7),
    .WB_TIMEOUT (15)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_total;
  int         n_pass;
  logic [7:0] mem [128];
  bit         ack_en;
  logic [6:0] log_adr [$];
  logic [7:0] log_dat [$];
  logic       log_we  [$];
  int         runs    [$];
  int         run_len;
  int         late_drop;
  logic [7:0] txb [4];
  logic [7:0] rxb [4];
  logic [7:0] rtmp;
  logic       oe_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      bus.mosi = b[i];
      wait_cyc(HALF);
      r[i]    = bus.miso;
      bus.sck = 1'b1;
      wait_cyc(HALF);
      bus.sck = 1'b0;
    end
  endtask

  task automatic do_frame(input int n);
    bus.cs = 1'b0;
    wait_cyc(HALF);
    oe_busy = bus.miso_oe & bus.busy;
    for (int k = 0; k < n; k++) spi_bits(txb[k], 8, rxb[k]);
    wait_cyc(HALF);
    bus.cs = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic clear_log();
    log_adr.delete();
    log_dat.delete();
    log_we.delete();
  endtask

  // Wishbone memory: ACK one cycle after CYC_O is seen, for exactly one edge
  initial begin
    bus.ACK_I = 1'b0;
    bus.DAT_I = 8'h00;
    run_len   = 0;
    late_drop = 0;
    for (int a = 0; a < 128; a++) mem[a] = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.ACK_I) begin
        bus.ACK_I = 1'b0;
        if (bus.CYC_O) late_drop++;
      end else if (bus.CYC_O && bus.STB_O && ack_en) begin
        if (bus.WE_O) mem[bus.ADR_O] = bus.DAT_O;
        bus.DAT_I = mem[bus.ADR_O];
        bus.ACK_I = 1'b1;
        log_adr.push_back(bus.ADR_O);
        log_dat.push_back(bus.DAT_O);
        log_we.push_back(bus.WE_O);
      end
      if (bus.CYC_O) run_len++;
      else if (run_len > 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
    end
  end

  initial begin
    n_total  = 0;
    n_pass   = 0;
    ack_en   = 1'b1;
    bus.sck  = 1'b0;
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    rst_n    = 1'b0;
    oe_busy  = 1'b0;
    wait_cyc(4);

    chk("rst_cyc",     32'(bus.CYC_O),   32'h0);
    chk("rst_stb",     32'(bus.STB_O),   32'h0);
    chk("rst_we",      32'(bus.WE_O),    32'h0);
    chk("rst_adr",     32'(bus.ADR_O),   32'h0);
    chk("rst_dat",     32'(bus.DAT_O),   32'h0);
    chk("rst_miso",    32'(bus.miso),    32'h0);
    chk("rst_miso_oe", 32'(bus.miso_oe), 32'h0);
    chk("rst_busy",    32'(bus.busy),    32'h0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Single write
    clear_log();
    txb[0] = 8'h05; txb[1] = 8'hA5;
    do_frame(2);
    chk("wr_oe_busy",  32'(oe_busy),        32'h1);
    chk("wr_status",   32'(rxb[0]),         32'h00);
    chk("wr_fill",     32'(rxb[1]),         32'h00);
    chk("wr_count",    32'(log_adr.size()), 32'd1);
    chk("wr_adr",      32'(log_adr[0]),     32'h05);
    chk("wr_dat",      32'(log_dat[0]),     32'hA5);
    chk("wr_we",       32'(log_we[0]),      32'h1);
    chk("wr_cyc_drop", 32'(late_drop),      32'd0);
    chk("wr_idle_busy",32'(bus.busy),       32'h0);

    // Burst read with prefetch
    clear_log();
    mem[7'h10] = 8'h11; mem[7'h11] = 8'h22;
    txb[0] = 8'h90; txb[1] = 8'h00; txb[2] = 8'h00;
    do_frame(3);
    chk("rd_status", 32'(rxb[0]),         32'h00);
    chk("rd_byte1",  32'(rxb[1]),         32'h11);
    chk("rd_byte2",  32'(rxb[2]),         32'h22);
    chk("rd_count",  32'(log_adr.size()), 32'd3);
    chk("rd_adr0",   32'(log_adr[0]),     32'h10);
    chk("rd_adr1",   32'(log_adr[1]),     32'h11);
    chk("rd_adr2",   32'(log_adr[2]),     32'h12);
    chk("rd_we",     32'({log_we[0], log_we[1], log_we[2]}), 32'h0);

    // Address wrap in a write burst
    clear_log();
    txb[0] = 8'h7F; txb[1] = 8'h01; txb[2] = 8'h02;
    do_frame(3);
    chk("wrap_count", 32'(log_adr.size()), 32'd2);
    chk("wrap_adr0",  32'(log_adr[0]),     32'h7F);
    chk("wrap_dat0",  32'(log_dat[0]),     32'h01);
    chk("wrap_adr1",  32'(log_adr[1]),     32'h00);
    chk("wrap_dat1",  32'(log_dat[1]),     32'h02);

    // Read against a slave that never acknowledges
    ack_en = 1'b0;
    runs.delete();
    txb[0] = 8'h83; txb[1] = 8'h00;
    do_frame(2);
    chk("tmo_status", 32'(rxb[0]),      32'h00);
    chk("tmo_data",   32'(rxb[1]),      32'hFF);
    chk("tmo_runs",   32'(runs.size()), 32'd2);
    chk("tmo_len",    32'(runs[0]),     32'd15);
    ack_en = 1'b1;

    // Abort after four data bits of a write
    clear_log();
    bus.cs = 1'b0;
    wait_cyc(HALF);
    spi_bits(8'h06, 8, rxb[0]);
    spi_bits(8'hA0, 4, rtmp);
    wait_cyc(HALF);
    bus.cs = 1'b1;
    wait_cyc(HALF);
    chk("abort_status", 32'(rxb[0]),         32'h40);
    chk("abort_no_wr",  32'(log_adr.size()), 32'd0);

    clear_log();
    txb[0] = 8'h01; txb[1] = 8'h3C;
    do_frame(2);
    chk("post_status", 32'(rxb[0]),         32'h00);
    chk("post_count",  32'(log_adr.size()), 32'd1);
    chk("post_adr",    32'(log_adr[0]),     32'h01);
    chk("post_dat",    32'(log_dat[0]),     32'h3C);

    // Reset while a read cycle is outstanding
    ack_en = 1'b0;
    bus.cs = 1'b0;
    wait_cyc(HALF);
    spi_bits(8'h85, 7, rtmp);
    bus.mosi = 1'b1;
    wait_cyc(HALF);
    bus.sck = 1'b1;
    for (int i = 0; i < 20 && bus.CYC_O !== 1'b1; i++) wait_cyc(1);
    chk("rst2_cyc_seen", 32'(bus.CYC_O), 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_cyc",     32'(bus.CYC_O),   32'h0);
    chk("rst2_stb",     32'(bus.STB_O),   32'h0);
    chk("rst2_busy",    32'(bus.busy),    32'h0);
    chk("rst2_miso_oe", 32'(bus.miso_oe), 32'h0);
    wait_cyc(2);
    bus.sck = 1'b0;
    bus.cs  = 1'b1;
    wait_cyc(4);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    wait_cyc(5);
    txb[0] = 8'h00;
    do_frame(1);
    chk("rst2_status", 32'(rxb[0]), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
